// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for seq_divider: operands in, held results out.
interface seq_divider_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (truncating toward zero).
module seq_divider #(
  parameter int W = 4
) (
  input logic           clk,
  input logic           rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state;
  logic [W:0]   r_q;
  logic [W-1:0] q_q;
  logic [W-1:0] d_q;
  logic [CW-1:0] cnt;
  logic         busy_q;
  logic         done_q;
  logic         dz_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] rem_q;

  logic [W+1:0] r_sh;
  logic [W+1:0] trial;
  logic [W:0]   r_nxt;
  logic [W-1:0] q_nxt;
  logic [W-1:0] quo_fin;
  logic [W-1:0] rem_fin;
  logic [W-1:0] dz_rem;
  logic [W-1:0] dvd_ld;
  logic [W-1:0] dvs_ld;

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;
  logic signed [W-1:0] dvd_s;
  logic signed [W-1:0] dvs_s;

  function automatic logic [W-1:0] sign_fix(input logic [W-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // Most-negative operand maps to itself, which is the correct unsigned magnitude.
  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
    return (v < 0) ? (~v + 1'b1) : v;
  endfunction
`endif

  always_comb begin
    r_sh  = {r_q, q_q[W-1]};
    trial = r_sh - {2'b00, d_q};
    if (trial[W+1]) begin
      r_nxt = r_sh[W:0];
      q_nxt = {q_q[W-2:0], 1'b0};
    end else begin
      r_nxt = trial[W:0];
      q_nxt = {q_q[W-2:0], 1'b1};
    end
`ifdef SIGNED_DIV_EN
    dvd_s   = bus.dividend;
    dvs_s   = bus.divisor;
    dvd_ld  = magnitude(dvd_s);
    dvs_ld  = magnitude(dvs_s);
    quo_fin = sign_fix(q_nxt, neg_q);
    rem_fin = sign_fix(r_nxt[W-1:0], neg_r);
    // Q still holds |dividend| on the zero-divisor path; restore its sign.
    dz_rem  = sign_fix(q_q, neg_r);
`else
    dvd_ld  = bus.dividend;
    dvs_ld  = bus.divisor;
    quo_fin = q_nxt;
    rem_fin = r_nxt[W-1:0];
    dz_rem  = q_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
`ifdef SIGNED_DIV_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            r_q    <= '0;
            q_q    <= dvd_ld;
            d_q    <= dvs_ld;
            cnt    <= CW'(W);
            busy_q <= 1'b1;
`ifdef SIGNED_DIV_EN
            neg_q  <= bus.dividend[W-1] ^ bus.divisor[W-1];
            neg_r  <= bus.dividend[W-1];
`endif
            state  <= (bus.divisor == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          r_q <= r_nxt;
          q_q <= q_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quo_q  <= quo_fin;
            rem_q  <= rem_fin;
            dz_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Entering DONE with done low means the zero-divisor shortcut.
          if (!done_q) begin
            quo_q  <= '1;
            rem_q  <= dz_rem;
            dz_q   <= 1'b1;
            done_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;
endmodule
